ifu_prefetcher_nline: RTL and testbench

//  Next-N-line instruction prefetcher; parametrised successor of the single-line IFU prefetcher.

---
 rtl/ifu_prefetcher_nline.sv | 167 ++++++++++++++++
 tb/tb_ifu_prefetcher_nline.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetcher_nline.sv
// ifu_prefetcher_nline
// Next-N-line instruction prefetcher. Each time the CPU enters a new line with
// tag T, it walks tags T+1..T+PREF_DEPTH. For each tag it probes the I-cache,
// and if the line is missing it requests it from memory. Up to MAX_PEND
// prefetches can be in flight. A tag that is already pending, or that the IFU
// is demand-fetching right now, is never requested again.
module ifu_prefetcher_nline #(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 4,
    parameter int PREF_DEPTH   = 4,
    parameter int MAX_PEND     = 4,
    parameter int SLEEP_CYCLES = 4
) (
    input  logic                               Clock,
    input  logic                               Rst_n,
    input  logic [ADDR_WIDTH-1:0]              cpu_reqAddrIn,
    input  logic                               ifu_demandValidIn,
    input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] ifu_demandTagIn,
    output logic                               cache_reqTagValidOut,
    output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] cache_reqTagOut,
    input  logic                               cache_rspTagValidIn,
    input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] cache_rspTagIn,
    input  logic                               cache_rspTagStatusIn,
    output logic                               mem_reqTagValidOut,
    output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] mem_reqTagOut,
    input  logic                               mem_reqReadyIn,
    input  logic                               mem_rspInsLineValidIn,
    input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] mem_rspTagIn,
    output logic [3:0]                         pend_countOut,
    output logic [1:0]                         current_stateOut
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_REQ   = 2'b10,
        S_SLEEP = 2'b11
    } state_t;

    state_t                 state;
    logic [TAG_WIDTH-1:0]   baseTag;
    logic [3:0]             k;
    logic [15:0]            sleepCnt;
    logic [MAX_PEND-1:0]    pendValid;
    logic [TAG_WIDTH-1:0]   pendTag [MAX_PEND];

    logic [TAG_WIDTH-1:0]   cpuTag;
    logic [TAG_WIDTH-1:0]   targetTag;
    logic                   tagChanged;
    logic                   demandHit;
    logic                   cacheMatch;
    logic                   targetReturned;
    logic                   targetPending;
    logic                   freeFound;
    logic [MAX_PEND-1:0]    allocMask;
    logic [3:0]             pendCount;
    logic                   memValid;
    logic                   issued;
    logic                   advance;
    logic                   lastStep;
    logic                   unusedOffset;

    assign cpuTag         = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign unusedOffset   = ^cpu_reqAddrIn[OFFSET_WIDTH-1:0];
    assign targetTag      = baseTag + TAG_WIDTH'(k);
    assign tagChanged     = (cpuTag != baseTag);
    assign demandHit      = ifu_demandValidIn && (ifu_demandTagIn == targetTag);
    assign cacheMatch     = cache_rspTagValidIn && (cache_rspTagIn == targetTag);
    assign targetReturned = mem_rspInsLineValidIn && (mem_rspTagIn == targetTag);
    assign lastStep       = (k == 4'(PREF_DEPTH));

    // Scan the pending table: is the target already in flight, which slot is the lowest free one, and how many slots are occupied
    always_comb begin
        targetPending = 1'b0;
        freeFound     = 1'b0;
        allocMask     = '0;
        pendCount     = '0;
        for (int i = 0; i < MAX_PEND; i++) begin
            if (pendValid[i] && (pendTag[i] == targetTag)) begin
                targetPending = 1'b1;
            end
            if (!pendValid[i] && !freeFound) begin
                freeFound    = 1'b1;
                allocMask[i] = 1'b1;
            end
            pendCount = pendCount + 4'(pendValid[i]);
        end
    end

    // Request valids are decoded from state and registers only; neither valid depends combinationally on a response input
    assign memValid = (state == S_REQ) && freeFound;
    assign issued   = memValid && mem_reqReadyIn;
    assign advance  = ((state == S_CHECK) && cacheMatch &&
                       (cache_rspTagStatusIn || targetPending || demandHit)) ||
                      ((state == S_REQ) && (issued || targetReturned || demandHit));

    assign cache_reqTagValidOut = (state == S_CHECK);
    assign cache_reqTagOut      = (state == S_CHECK) ? targetTag : '0;
    assign mem_reqTagValidOut   = memValid;
    assign mem_reqTagOut        = memValid ? targetTag : '0;
    assign pend_countOut        = pendCount;
    assign current_stateOut     = state;

    // Walk FSM: latch the base tag, then probe and request each target in turn; a CPU tag change aborts the walk
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            baseTag  <= '0;
            k        <= '0;
            sleepCnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    baseTag <= cpuTag;
                    k       <= 4'd1;
                    state   <= S_CHECK;
                end
                S_CHECK, S_REQ: begin
                    if (tagChanged) begin
                        state <= S_IDLE;
                    end else if (advance) begin
                        if (lastStep) begin
                            state    <= S_SLEEP;
                            sleepCnt <= '0;
                        end else begin
                            k     <= k + 4'd1;
                            state <= S_CHECK;
                        end
                    end else if ((state == S_CHECK) && cacheMatch) begin
                        state <= S_REQ;
                    end
                end
                S_SLEEP: begin
                    if (tagChanged || (sleepCnt == 16'(SLEEP_CYCLES - 1))) begin
                        state <= S_IDLE;
                    end else begin
                        sleepCnt <= sleepCnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pending table: allocate on a handshake, clear on a matching line return; an issued request stays tracked even if the walk aborts
    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            pendValid <= '0;
            for (int i = 0; i < MAX_PEND; i++) begin
                pendTag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_PEND; i++) begin
                if (issued && allocMask[i]) begin
                    pendValid[i] <= 1'b1;
                    pendTag[i]   <= targetTag;
                end else if (mem_rspInsLineValidIn && pendValid[i] &&
                             (pendTag[i] == mem_rspTagIn)) begin
                    pendValid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetcher_nline.sv
// Testbench for ifu_prefetcher_nline with the default parameters.
// A small cache model answers every probe one cycle later. A line counts as
// present once memory has returned it, or once the bench preloads it. Every
// expected memory request tag goes into a queue, and each valid&ready handshake
// pops the front of that queue and compares against it.
module tb_ifu_prefetcher_nline;

    localparam int TW = 28;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_REQ   = 2'b10;
    localparam logic [1:0] ST_SLEEP = 2'b11;

    logic          Clock = 1'b0;
    logic          Rst_n;
    logic [31:0]   cpuAddr;
    logic          demandValid;
    logic [TW-1:0] demandTag;
    logic          cacheReqValid;
    logic [TW-1:0] cacheReqTag;
    logic          cacheRspValid;
    logic [TW-1:0] cacheRspTag;
    logic          cacheRspStatus;
    logic          memReqValid;
    logic [TW-1:0] memReqTag;
    logic          memReady;
    logic          memRspValid;
    logic [TW-1:0] memRspTag;
    logic [3:0]    pendCount;
    logic [1:0]    currentState;

    int            compared   = 0;
    int            mismatched = 0;
    logic [TW-1:0] expectedQ [$];
    bit            cacheLines [logic [TW-1:0]];
    logic          probeV = 1'b0;
    logic [TW-1:0] probeT = '0;

    always #5 Clock = ~Clock;

    ifu_prefetcher_nline dut (
        .Clock                 (Clock),
        .Rst_n                 (Rst_n),
        .cpu_reqAddrIn         (cpuAddr),
        .ifu_demandValidIn     (demandValid),
        .ifu_demandTagIn       (demandTag),
        .cache_reqTagValidOut  (cacheReqValid),
        .cache_reqTagOut       (cacheReqTag),
        .cache_rspTagValidIn   (cacheRspValid),
        .cache_rspTagIn        (cacheRspTag),
        .cache_rspTagStatusIn  (cacheRspStatus),
        .mem_reqTagValidOut    (memReqValid),
        .mem_reqTagOut         (memReqTag),
        .mem_reqReadyIn        (memReady),
        .mem_rspInsLineValidIn (memRspValid),
        .mem_rspTagIn          (memRspTag),
        .pend_countOut         (pendCount),
        .current_stateOut      (currentState)
    );

    // Count one comparison and report it if the observed value differs from the expected one
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a new CPU fetch address and memory ready, just after a falling edge
    task automatic applyStimulus(input logic [31:0] addr, input logic ready);
        @(negedge Clock);
        #1;
        cpuAddr  = addr;
        memReady = ready;
    endtask

    // Memory returns one line for a cycle; from then on the cache model holds that line
    task automatic returnLine(input logic [TW-1:0] tag);
        @(negedge Clock);
        #1;
        memRspValid     = 1'b1;
        memRspTag       = tag;
        cacheLines[tag] = 1'b1;
        @(negedge Clock);
        #1;
        memRspValid = 1'b0;
    endtask

    // Queue the expected request tags base+first .. base+last
    task automatic pushExpected(input logic [TW-1:0] base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            expectedQ.push_back(base + TW'(i));
        end
    endtask

    // Wait (bounded) for the FSM to reach a state; if the bound runs out, the final compare fails
    task automatic waitState(input logic [1:0] s, input string tag);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while ((currentState !== s) && (n < 300));
        checkOutput(tag, 32'(currentState), 32'(s));
    endtask

    // Wait (bounded) for the pending count to reach a value
    task automatic waitPend(input logic [3:0] p, input string tag);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while ((pendCount !== p) && (n < 300));
        checkOutput(tag, 32'(pendCount), 32'(p));
    endtask

    // Cache model: capture the probe away from the edge
    always @(negedge Clock) begin
        probeV = cacheReqValid;
        probeT = cacheReqTag;
    end

    // Cache model: answer the captured probe just after the next rising edge
    always @(posedge Clock) begin
        #1;
        cacheRspValid  = probeV;
        cacheRspTag    = probeT;
        cacheRspStatus = probeV && cacheLines.exists(probeT);
    end

    // Scoreboard: every handshake must match the head of the expected queue, and the two request valids must never be high together
    always @(negedge Clock) begin
        checkOutput("exclusiveValids", 32'(cacheReqValid & memReqValid), 32'h0);
        if (memReqValid && memReady) begin
            if (expectedQ.size() == 0) begin
                checkOutput("spuriousReq", 32'(memReqTag), 32'hFFFF_FFFF);
            end else begin
                checkOutput("memReqTag", 32'(memReqTag), 32'(expectedQ.pop_front()));
            end
        end
    end

    // Main test sequence
    initial begin
        Rst_n          = 1'b0;
        cpuAddr        = 32'h100;
        demandValid    = 1'b0;
        demandTag      = '0;
        memReady       = 1'b1;
        memRspValid    = 1'b0;
        memRspTag      = '0;
        cacheRspValid  = 1'b0;
        cacheRspTag    = '0;
        cacheRspStatus = 1'b0;

        repeat (3) @(negedge Clock);
        checkOutput("resetState",    32'(currentState),  32'(ST_IDLE));
        checkOutput("resetCacheVal", 32'(cacheReqValid), 32'h0);
        checkOutput("resetCacheTag", 32'(cacheReqTag),   32'h0);
        checkOutput("resetMemVal",   32'(memReqValid),   32'h0);
        checkOutput("resetMemTag",   32'(memReqTag),     32'h0);
        checkOutput("resetPend",     32'(pendCount),     32'h0);

        // T1: every probe misses, so 0x11..0x14 are requested in order
        $display("[TB] T1 all-miss walk");
        pushExpected(28'h10, 1, 4);
        @(negedge Clock);
        #1 Rst_n = 1'b1;
        waitState(ST_SLEEP, "T1 sleep");
        checkOutput("T1 pend",  32'(pendCount), 32'd4);
        checkOutput("T1 queue", 32'(expectedQ.size()), 32'd0);
        repeat (30) @(negedge Clock);
        checkOutput("T1 pendAfterRewalk", 32'(pendCount), 32'd4);

        // T3: table full, so the walk stalls on 0x21 until a line returns
        $display("[TB] T3 full-table stall");
        pushExpected(28'h20, 1, 1);
        applyStimulus(32'h200, 1'b1);
        waitState(ST_REQ, "T3 stallState");
        repeat (3) @(negedge Clock);
        checkOutput("T3 stallValid", 32'(memReqValid),  32'h0);
        checkOutput("T3 stillReq",   32'(currentState), 32'(ST_REQ));
        checkOutput("T3 stallPend",  32'(pendCount),    32'd4);
        pushExpected(28'h20, 2, 4);
        for (int i = 1; i <= 4; i++) returnLine(28'h10 + TW'(i));
        waitState(ST_SLEEP, "T3 sleep");
        checkOutput("T3 pend",  32'(pendCount), 32'd4);
        checkOutput("T3 queue", 32'(expectedQ.size()), 32'd0);
        for (int i = 1; i <= 4; i++) returnLine(28'h20 + TW'(i));
        repeat (20) @(negedge Clock);
        checkOutput("T3 drained", 32'(pendCount), 32'd0);

        // T2: 0x32 already cached, so it is skipped
        $display("[TB] T2 cache hit skip");
        cacheLines[28'h32] = 1'b1;
        pushExpected(28'h30, 1, 1);
        pushExpected(28'h30, 3, 4);
        applyStimulus(32'h300, 1'b1);
        waitState(ST_SLEEP, "T2 sleep");
        checkOutput("T2 pend",  32'(pendCount), 32'd3);
        checkOutput("T2 queue", 32'(expectedQ.size()), 32'd0);
        returnLine(28'h31);
        returnLine(28'h33);
        returnLine(28'h34);

        // Demand: IFU is fetching 0x42 itself, so the prefetcher skips it
        $display("[TB] demand skip");
        demandValid = 1'b1;
        demandTag   = 28'h42;
        pushExpected(28'h40, 1, 1);
        pushExpected(28'h40, 3, 4);
        applyStimulus(32'h400, 1'b1);
        waitState(ST_SLEEP, "DM sleep");
        checkOutput("DM pend",  32'(pendCount), 32'd3);
        checkOutput("DM queue", 32'(expectedQ.size()), 32'd0);
        cacheLines[28'h42] = 1'b1;
        demandValid = 1'b0;
        returnLine(28'h41);
        returnLine(28'h43);
        returnLine(28'h44);

        // T4: all-ones tag, so the targets wrap to 0..3
        $display("[TB] T4 tag wrap");
        pushExpected(28'h0, 0, 3);
        applyStimulus(32'hFFFF_FFF0, 1'b1);
        waitState(ST_SLEEP, "T4 sleep");
        checkOutput("T4 pend",  32'(pendCount), 32'd4);
        checkOutput("T4 queue", 32'(expectedQ.size()), 32'd0);
        for (int i = 0; i < 4; i++) returnLine(TW'(i));

        // T5: request held without ready, then withdrawn by a CPU tag change
        $display("[TB] T5 abort withdraws request");
        applyStimulus(32'h500, 1'b0);
        waitState(ST_REQ, "T5 req");
        checkOutput("T5 valid", 32'(memReqValid), 32'h1);
        checkOutput("T5 tag",   32'(memReqTag),   32'h51);
        repeat (3) @(negedge Clock);
        checkOutput("T5 heldValid", 32'(memReqValid), 32'h1);
        checkOutput("T5 heldTag",   32'(memReqTag),   32'h51);
        applyStimulus(32'h600, 1'b0);
        @(negedge Clock);
        checkOutput("T5 abortState", 32'(currentState), 32'(ST_IDLE));
        checkOutput("T5 abortValid", 32'(memReqValid),  32'h0);
        pushExpected(28'h60, 1, 4);
        #1 memReady = 1'b1;
        waitState(ST_SLEEP, "T5 sleep");
        checkOutput("T5 pend",  32'(pendCount), 32'd4);
        checkOutput("T5 queue", 32'(expectedQ.size()), 32'd0);
        for (int i = 1; i <= 4; i++) returnLine(28'h60 + TW'(i));

        // T6: asynchronous reset in the middle of S_REQ
        $display("[TB] T6 async reset");
        pushExpected(28'h70, 1, 3);
        applyStimulus(32'h700, 1'b1);
        waitPend(4'd3, "T6 pend3");
        #1 memReady = 1'b0;
        waitState(ST_REQ, "T6 inReq");
        #2 Rst_n = 1'b0;
        #1;
        checkOutput("T6 rstState",    32'(currentState),  32'(ST_IDLE));
        checkOutput("T6 rstMemVal",   32'(memReqValid),   32'h0);
        checkOutput("T6 rstMemTag",   32'(memReqTag),     32'h0);
        checkOutput("T6 rstCacheVal", 32'(cacheReqValid), 32'h0);
        checkOutput("T6 rstPend",     32'(pendCount),     32'd0);
        pushExpected(28'h70, 1, 4);
        memReady = 1'b1;
        @(negedge Clock);
        #1 Rst_n = 1'b1;
        waitState(ST_SLEEP, "T6 sleep");
        checkOutput("T6 pend",  32'(pendCount), 32'd4);
        checkOutput("T6 queue", 32'(expectedQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
